// File: rtl/approx_acc_stage.sv
// Accumulator stage of the approximate PE datapath: sums up to NUM_TERMS products
// using a carry-free low part, saturates on overflow and holds each result until popped.
module approx_acc_stage #(
    parameter int DATA_W    = 16,
    parameter int ACC_W     = 32,
    parameter int IMP_W     = 16,
    parameter int NUM_TERMS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_ovf
);

    localparam int CNT_W = $clog2(NUM_TERMS + 1);
    localparam int HI_W  = ACC_W - IMP_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_q;
    logic               out_valid_q;
    logic [ACC_W-1:0]   out_data_q;
    logic               out_ovf_q;

    logic [ACC_W-1:0]   beat_d;
    logic [ACC_W:0]     sum_d;
    logic [ACC_W-1:0]   acc_d;
    logic               ovf_d;
    logic               close_d;
    logic               beat_ok_d;

    // Low part copied from the incoming operand; the top bit of the old low part
    // stands in for the carry that the low part never generates.
    function automatic logic [ACC_W:0] approx_add(input logic [ACC_W-1:0] a,
                                                  input logic [ACC_W-1:0] b);
        logic [HI_W:0] hi;
        hi = {1'b0, a[ACC_W-1:IMP_W]} + {1'b0, b[ACC_W-1:IMP_W]}
           + {{HI_W{1'b0}}, a[IMP_W-1]};
        return {hi, b[IMP_W-1:0]};
    endfunction

    assign in_ready  = rst_n && (state_q != ST_DONE);
    assign beat_ok_d = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

    // Next accumulator value for a beat arriving while a group is open.
    always_comb begin
        beat_d  = ACC_W'(in_data);
        sum_d   = approx_add(acc_q, beat_d);
        acc_d   = sum_d[ACC_W-1:0];
        ovf_d   = 1'b0;
        close_d = in_last || (cnt_q == CNT_W'(NUM_TERMS - 1));
        if (ovf_q || sum_d[ACC_W]) begin
            acc_d = {ACC_W{1'b1}};
            ovf_d = 1'b1;
        end else begin
            acc_d = sum_d[ACC_W-1:0];
            ovf_d = 1'b0;
        end
    end

    // Group state machine with registered result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= {ACC_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= {ACC_W{1'b0}};
            out_ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (beat_ok_d) begin
                        acc_q <= beat_d;
                        cnt_q <= CNT_W'(1);
                        ovf_q <= 1'b0;
                        if ((NUM_TERMS == 1) || in_last) begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                            out_data_q  <= beat_d;
                            out_ovf_q   <= 1'b0;
                        end else begin
                            state_q <= ST_ACCUM;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (beat_ok_d) begin
                        acc_q <= acc_d;
                        ovf_q <= ovf_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (close_d) begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                            out_data_q  <= acc_d;
                            out_ovf_q   <= ovf_d;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        acc_q       <= {ACC_W{1'b0}};
                        cnt_q       <= {CNT_W{1'b0}};
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    acc_q       <= {ACC_W{1'b0}};
                    cnt_q       <= {CNT_W{1'b0}};
                    ovf_q       <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
